// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS MEM stage: access FSM states,
// default widths and the word-alignment helper.
package mips_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_TIMEOUT    = 255;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return |(addr_lsb & WORD_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master)
// and the data memory (slave).
interface mem_stage_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/dmem_fsm.sv
// Data-memory access sequencer: IDLE -> BUSY (wait for ack or timeout) -> DONE,
// owning the registered request, the captured load data and the bus-error flag.
module dmem_fsm
  import mips_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_we,
  input  logic [DATA_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_wdata,
  mem_stage_if.master       bus,
  output mem_state_t        state,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              timed_out,
  output logic              bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t        state_r, state_nxt_s;
  logic              req_r, req_nxt_s;
  logic              we_r, we_nxt_s;
  logic [DATA_W-1:0] addr_r, addr_nxt_s;
  logic [DATA_W-1:0] wdata_r, wdata_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
  logic              timed_out_r, timed_out_nxt_s;
  logic              bus_error_r, bus_error_nxt_s;
  logic              stall_s;

  // Next-state, handshake register and stall decode.
  always_comb begin
    state_nxt_s     = state_r;
    req_nxt_s       = req_r;
    we_nxt_s        = we_r;
    addr_nxt_s      = addr_r;
    wdata_nxt_s     = wdata_r;
    cnt_nxt_s       = cnt_r;
    rdata_nxt_s     = rdata_r;
    timed_out_nxt_s = timed_out_r;
    bus_error_nxt_s = bus_error_r;
    stall_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          stall_s         = ~reset;
          state_nxt_s     = BUSY;
          req_nxt_s       = 1'b1;
          we_nxt_s        = start_we;
          addr_nxt_s      = start_addr;
          wdata_nxt_s     = start_wdata;
          cnt_nxt_s       = {CNT_W{1'b0}};
          rdata_nxt_s     = {DATA_W{1'b0}};
          timed_out_nxt_s = 1'b0;
        end else begin
          stall_s = 1'b0;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus.dmem_ack) begin
          req_nxt_s   = 1'b0;
          rdata_nxt_s = we_r ? {DATA_W{1'b0}} : bus.dmem_rdata;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = DONE;
        end else if (cnt_r == CNT_LAST) begin
          req_nxt_s       = 1'b0;
          rdata_nxt_s     = {DATA_W{1'b0}};
          cnt_nxt_s       = {CNT_W{1'b0}};
          timed_out_nxt_s = 1'b1;
          bus_error_nxt_s = 1'b1;
          state_nxt_s     = DONE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  // State and handshake registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      req_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= {DATA_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      timed_out_r <= 1'b0;
      bus_error_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      req_r       <= req_nxt_s;
      we_r        <= we_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rdata_r     <= rdata_nxt_s;
      timed_out_r <= timed_out_nxt_s;
      bus_error_r <= bus_error_nxt_s;
    end
  end

  assign bus.dmem_req   = req_r;
  assign bus.dmem_we    = we_r;
  assign bus.dmem_addr  = addr_r;
  assign bus.dmem_wdata = wdata_r;

  assign state     = state_r;
  assign stall     = stall_s;
  assign rdata     = rdata_r;
  assign timed_out = timed_out_r;
  assign bus_error = bus_error_r;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: launches data-memory accesses through dmem_fsm, resolves the
// branch decision and drives the MEM/WB pipeline register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_regWrite_ex_mem,
  input  logic                  ctrl_memToReg_ex_mem,
  input  logic                  ctrl_branch_ex_mem,
  input  logic                  ctrl_memRead_ex_mem,
  input  logic                  ctrl_memWrite_ex_mem,
  input  logic                  zero_ex_mem,
  input  logic [DATA_W-1:0]     branch_or_not_address_ex_mem,
  input  logic [DATA_W-1:0]     alu_result_ex_mem,
  input  logic [DATA_W-1:0]     read_data_2_ex_mem,
  input  logic [REG_ADDR_W-1:0] write_register_ex_mem,
  mem_stage_if.master           dmem,
  output logic                  pcsrc,
  output logic [DATA_W-1:0]     branch_target,
  output logic                  stall_mem,
  output logic                  misaligned_err,
  output logic                  bus_error,
  output logic                  ctrl_regWrite_mem_wb,
  output logic                  ctrl_memToReg_mem_wb,
  output logic [DATA_W-1:0]     read_data_mem_wb,
  output logic [DATA_W-1:0]     alu_result_mem_wb,
  output logic [REG_ADDR_W-1:0] write_register_mem_wb
);

  logic              acc_s, mis_s, start_s, done_s;
  mem_state_t        state_s;
  logic              stall_s, timed_out_s, bus_error_s;
  logic [DATA_W-1:0] cap_rdata_s;

  logic                  wb_rw_r, wb_rw_nxt_s;
  logic                  wb_m2r_r, wb_m2r_nxt_s;
  logic [DATA_W-1:0]     wb_rdata_r, wb_rdata_nxt_s;
  logic [DATA_W-1:0]     wb_alu_r, wb_alu_nxt_s;
  logic [REG_ADDR_W-1:0] wb_rd_r, wb_rd_nxt_s;

  assign acc_s   = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
  assign mis_s   = acc_s & is_misaligned(alu_result_ex_mem[1:0]);
  assign start_s = acc_s & ~mis_s;
  assign done_s  = (state_s == DONE);

  dmem_fsm #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_dmem_fsm (
    .clk         (clk),
    .reset       (reset),
    .start       (start_s),
    .start_we    (ctrl_memWrite_ex_mem),
    .start_addr  (alu_result_ex_mem),
    .start_wdata (read_data_2_ex_mem),
    .bus         (dmem),
    .state       (state_s),
    .stall       (stall_s),
    .rdata       (cap_rdata_s),
    .timed_out   (timed_out_s),
    .bus_error   (bus_error_s)
  );

  // MEM/WB next value: bubble while stalled, otherwise advance the EX/MEM instruction.
  always_comb begin
    wb_rw_nxt_s    = wb_rw_r;
    wb_m2r_nxt_s   = wb_m2r_r;
    wb_rdata_nxt_s = wb_rdata_r;
    wb_alu_nxt_s   = wb_alu_r;
    wb_rd_nxt_s    = wb_rd_r;
    if (stall_s) begin
      wb_rw_nxt_s  = 1'b0;
      wb_m2r_nxt_s = 1'b0;
    end else begin
      wb_rw_nxt_s    = ctrl_regWrite_ex_mem & ~mis_s & ~(done_s & timed_out_s);
      wb_m2r_nxt_s   = ctrl_memToReg_ex_mem & ~mis_s;
      wb_rdata_nxt_s = (done_s & ctrl_memRead_ex_mem) ? cap_rdata_s : {DATA_W{1'b0}};
      wb_alu_nxt_s   = alu_result_ex_mem;
      wb_rd_nxt_s    = write_register_ex_mem;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_rw_r    <= 1'b0;
      wb_m2r_r   <= 1'b0;
      wb_rdata_r <= {DATA_W{1'b0}};
      wb_alu_r   <= {DATA_W{1'b0}};
      wb_rd_r    <= {REG_ADDR_W{1'b0}};
    end else begin
      wb_rw_r    <= wb_rw_nxt_s;
      wb_m2r_r   <= wb_m2r_nxt_s;
      wb_rdata_r <= wb_rdata_nxt_s;
      wb_alu_r   <= wb_alu_nxt_s;
      wb_rd_r    <= wb_rd_nxt_s;
    end
  end

  assign pcsrc          = ctrl_branch_ex_mem & zero_ex_mem;
  assign branch_target  = branch_or_not_address_ex_mem;
  assign stall_mem      = stall_s;
  assign misaligned_err = mis_s & (state_s == IDLE) & ~reset;
  assign bus_error      = bus_error_s;

  assign ctrl_regWrite_mem_wb  = wb_rw_r;
  assign ctrl_memToReg_mem_wb  = wb_m2r_r;
  assign read_data_mem_wb      = wb_rdata_r;
  assign alu_result_mem_wb     = wb_alu_r;
  assign write_register_mem_wb = wb_rd_r;

endmodule
